axil_write_ctrl: RTL and testbench
==================================

AXIL_WRITE_CTRL -- requirements
Module: axil_write_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width; legal values are 32 and 64.
REQ-003 Parameter ERR_RESP_EN, default 1'b0, enables SLVERR on misaligned AW or all-zero WSTRB.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 s_axi_awaddr  input  ADDR_WIDTH  write address.
REQ-007 s_axi_awvalid / s_axi_awready  input / output  1  AW handshake.
REQ-008 s_axi_wdata  input  DATA_WIDTH  write data.
REQ-009 s_axi_wstrb  input  DATA_WIDTH/8  byte strobes.
REQ-010 s_axi_wvalid / s_axi_wready  input / output  1  W handshake.
REQ-011 s_axi_bresp  output  2  write response.
REQ-012 s_axi_bvalid / s_axi_bready  output / input  1  B handshake.
REQ-013 reg_wr_en_o  output  1  one-cycle register-file write strobe.
REQ-014 reg_wr_addr_o / reg_wr_data_o / reg_wr_strb_o  output  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  captured write beat.

Function
REQ-015 FSM states: IDLE, WAIT_W (AW held), WAIT_AW (W held), WRITE, RESP.
REQ-016 s_axi_awready SHALL be 1 in IDLE and WAIT_AW only.
REQ-017 s_axi_wready SHALL be 1 in IDLE and WAIT_W only.
REQ-018 The address SHALL be captured on the AW handshake, and data and strobes on the W handshake.
REQ-019 IDLE transitions: AW only -> WAIT_W; W only -> WAIT_AW; both in the same cycle -> WRITE (or RESP on error).
REQ-020 Error flags SHALL be sampled at the respective handshake and OR-ed into a sticky err bit, which clears on entry to IDLE.
REQ-021 On completion of the second handshake in cycle N without error, the FSM SHALL enter WRITE; reg_wr_en_o=1 in cycle N+1 only; s_axi_bvalid=1 from N+2 with bresp=OKAY (2'b00).
REQ-022 On completion of the second handshake in cycle N with error, the FSM SHALL skip WRITE: no reg_wr_en_o pulse; s_axi_bvalid=1 from N+1 with bresp=SLVERR (2'b10).
REQ-023 In RESP, s_axi_bvalid and s_axi_bresp SHALL remain stable until s_axi_bready; on that handshake the FSM SHALL enter IDLE, and bvalid=0 in the next cycle.
REQ-024 At most one outstanding transaction; both readies SHALL be 0 in WRITE and RESP.
REQ-025 reg_wr_addr_o, reg_wr_data_o and reg_wr_strb_o SHALL be registered and SHALL hold their last captured values outside WRITE.
REQ-026 With ERR_RESP_EN=0, bresp SHALL always be OKAY.

Reset
REQ-027 With rst_i=1 at a clock edge: state=IDLE; bvalid=0; bresp=00; reg_wr_en_o=0; captured addr/data/strb=0; err=0.
REQ-028 A reset mid-transaction SHALL discard the held beat and issue no write strobe or response.

Configuration
REQ-029 Macro AXIL_WR_ERR_CNT_EN: when defined, adds output err_cnt_o (16 bits), incremented on each SLVERR B handshake, saturating at 16'hFFFF, and cleared by reset.
REQ-030 Without AXIL_WR_ERR_CNT_EN, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package axil_pkg SHALL hold the resp_t localparams (OKAY=2'b00, SLVERR=2'b10) and the wr_state_t enum.
REQ-032 One sub-module: protocol_checker SHALL be instantiated for err_awrite/err_write, with the AR inputs tied to 0 and err_read left unused.

Verification
REQ-033 AW and W in the same cycle, addr=0x10, data=0xDEADBEEF, strb=0xF -> reg_wr_en_o 1 cycle later with the same values; bresp=00 at N+2.
REQ-034 AW at cycle 0, W at cycle 3 -> wready=1 and awready=0 in cycles 1-3; single write; response OKAY.
REQ-035 ERR_RESP_EN=1, awaddr=0x12 -> no reg_wr_en_o; bvalid at N+1 with bresp=2'b10.
REQ-036 ERR_RESP_EN=1, wstrb=0 -> SLVERR; with AXIL_WR_ERR_CNT_EN defined, err_cnt_o increments to 1.
REQ-037 bready held low 5 cycles -> bvalid and bresp stable, both readies 0; release -> IDLE next cycle.
REQ-038 rst_i asserted in WAIT_W -> IDLE, no strobe, no bvalid; a subsequent full write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite write controller.
//   resp_t     : 2-bit AXI write response code (OKAY / SLVERR)
//   wr_state_t : write-channel FSM state encoding
//   ERR_CNT_WIDTH : width of the optional SLVERR counter
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam int unsigned ERR_CNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_W  = 3'd1,
        WAIT_AW = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } wr_state_t;

endpackage

// File: rtl/protocol_checker.sv
// Combinational AXI-Lite beat checker.
//   i_awvalid/i_awaddr : write address beat -> o_err_awrite when misaligned
//   i_wvalid/i_wstrb   : write data beat    -> o_err_write when no byte enabled
//   i_arvalid/i_araddr : read address beat  -> o_err_read when misaligned
// Flags are only raised while the corresponding valid is high.
module protocol_checker #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    i_awvalid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_wvalid,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_arvalid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    output logic                    o_err_awrite,
    output logic                    o_err_write,
    output logic                    o_err_read
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // Byte-offset bits inside one data word; any set bit means misaligned.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);

    logic w_aw_misaligned;
    logic w_ar_misaligned;
    logic w_strb_empty;

    assign w_aw_misaligned = (i_awaddr & ALIGN_MASK) != '0;
    assign w_ar_misaligned = (i_araddr & ALIGN_MASK) != '0;
    assign w_strb_empty    = (i_wstrb == '0);

    assign o_err_awrite = i_awvalid & w_aw_misaligned;
    assign o_err_write  = i_wvalid  & w_strb_empty;
    assign o_err_read   = i_arvalid & w_ar_misaligned;

endmodule

// File: rtl/axil_write_ctrl.sv
// AXI-Lite write-channel slave that turns one AW/W pair into a single-cycle
// register-file write strobe followed by a B response.
//
// Ports
//   clk_i, rst_i                       : clock, synchronous active-high reset
//   s_axi_aw*                          : write address channel
//   s_axi_w*                           : write data channel
//   s_axi_b*                           : write response channel
//   reg_wr_en_o                        : one-cycle write strobe
//   reg_wr_addr_o/data_o/strb_o        : captured beat, held between writes
//   err_cnt_o                          : saturating SLVERR count (only with
//                                        AXIL_WR_ERR_CNT_EN defined)
//
// Build option
//   AXIL_WR_ERR_CNT_EN : adds err_cnt_o and its counter.
module axil_write_ctrl
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          ERR_RESP_EN = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [DATA_WIDTH-1:0]    s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]  s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
`ifdef AXIL_WR_ERR_CNT_EN
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
`endif
    output logic                     reg_wr_en_o,
    output logic [ADDR_WIDTH-1:0]    reg_wr_addr_o,
    output logic [DATA_WIDTH-1:0]    reg_wr_data_o,
    output logic [DATA_WIDTH/8-1:0]  reg_wr_strb_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    wr_state_t               r_state;
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_bvalid;
    resp_t                   r_bresp;
    logic                    r_wr_en;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [STRB_WIDTH-1:0]   r_strb;

    logic w_chk_aw_err;
    logic w_chk_w_err;
    logic w_unused_err_read;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_aw_err;
    logic w_w_err;
    logic w_err_next;
    logic w_complete;

    // Beat checker; the read-address side is not used by this block.
    protocol_checker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checker (
        .i_awvalid    (s_axi_awvalid),
        .i_awaddr     (s_axi_awaddr),
        .i_wvalid     (s_axi_wvalid),
        .i_wstrb      (s_axi_wstrb),
        .i_arvalid    (1'b0),
        .i_araddr     ('0),
        .o_err_awrite (w_chk_aw_err),
        .o_err_write  (w_chk_w_err),
        .o_err_read   (w_unused_err_read)
    );

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid  & r_wready;
    assign w_b_hs  = r_bvalid      & s_axi_bready;

    // Error reporting is optional; when disabled the checker flags are ignored.
    assign w_aw_err = ERR_RESP_EN & w_chk_aw_err;
    assign w_w_err  = ERR_RESP_EN & w_chk_w_err;

    // Sticky error including whatever this cycle's handshakes contribute.
    assign w_err_next = r_err | (w_aw_hs & w_aw_err) | (w_w_hs & w_w_err);

    // The second of the two handshakes lands this cycle.
    assign w_complete = ((r_state == IDLE)    && w_aw_hs && w_w_hs) ||
                        ((r_state == WAIT_W)  && w_w_hs)            ||
                        ((r_state == WAIT_AW) && w_aw_hs);

    // Write FSM with registered readies, strobe and response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_wr_en   <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_strb    <= '0;
        end else begin
            r_wr_en <= 1'b0;

            if (w_aw_hs) begin
                r_addr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_data <= s_axi_wdata;
                r_strb <= s_axi_wstrb;
            end

            case (r_state)
                IDLE, WAIT_W, WAIT_AW: begin
                    r_err <= w_err_next;
                    if (w_complete) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        if (w_err_next) begin
                            // Erroneous pair skips the register write.
                            r_state  <= RESP;
                            r_bvalid <= 1'b1;
                            r_bresp  <= RESP_SLVERR;
                        end else begin
                            r_state <= WRITE;
                            r_wr_en <= 1'b1;
                        end
                    end else if (w_aw_hs) begin
                        r_state   <= WAIT_W;
                        r_awready <= 1'b0;
                    end else if (w_w_hs) begin
                        r_state  <= WAIT_AW;
                        r_wready <= 1'b0;
                    end
                end

                WRITE: begin
                    r_state  <= RESP;
                    r_bvalid <= 1'b1;
                    r_bresp  <= RESP_OKAY;
                end

                RESP: begin
                    if (w_b_hs) begin
                        r_state   <= IDLE;
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_err     <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_bvalid  <= 1'b0;
                    r_bresp   <= RESP_OKAY;
                    r_err     <= 1'b0;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef AXIL_WR_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    // Count SLVERR responses as they are accepted, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_b_hs && (r_bresp == RESP_SLVERR) && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign reg_wr_en_o   = r_wr_en;
    assign reg_wr_addr_o = r_addr;
    assign reg_wr_data_o = r_data;
    assign reg_wr_strb_o = r_strb;

endmodule

// File: tb/tb_axil_write_ctrl.sv
// Bench for axil_write_ctrl: instance 0 has error responses disabled,
// instance 1 has them enabled. Expected behaviour comes from a per-cycle
// transaction model derived from handshake ordering and latency rules.
module tb_axil_write_ctrl;
    import axil_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int unsigned NDUT = 2;

    logic          clk;
    logic          rst     [NDUT];
    logic [AW-1:0] awaddr  [NDUT];
    logic          awvalid [NDUT];
    logic          awready [NDUT];
    logic [DW-1:0] wdata   [NDUT];
    logic [SW-1:0] wstrb   [NDUT];
    logic          wvalid  [NDUT];
    logic          wready  [NDUT];
    logic [1:0]    bresp   [NDUT];
    logic          bvalid  [NDUT];
    logic          bready  [NDUT];
    logic          wr_en   [NDUT];
    logic [AW-1:0] wr_addr [NDUT];
    logic [DW-1:0] wr_data [NDUT];
    logic [SW-1:0] wr_strb [NDUT];
`ifdef AXIL_WR_ERR_CNT_EN
    logic [15:0]   err_cnt [NDUT];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the captured beat and of the SLVERR count per instance.
    logic [AW-1:0] m_addr [NDUT];
    logic [DW-1:0] m_data [NDUT];
    logic [SW-1:0] m_strb [NDUT];
    int            m_err_cnt [NDUT];

    axil_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_RESP_EN(1'b0)) u_dut0 (
        .clk_i         (clk),
        .rst_i         (rst[0]),
        .s_axi_awaddr  (awaddr[0]),
        .s_axi_awvalid (awvalid[0]),
        .s_axi_awready (awready[0]),
        .s_axi_wdata   (wdata[0]),
        .s_axi_wstrb   (wstrb[0]),
        .s_axi_wvalid  (wvalid[0]),
        .s_axi_wready  (wready[0]),
        .s_axi_bresp   (bresp[0]),
        .s_axi_bvalid  (bvalid[0]),
        .s_axi_bready  (bready[0]),
`ifdef AXIL_WR_ERR_CNT_EN
        .err_cnt_o     (err_cnt[0]),
`endif
        .reg_wr_en_o   (wr_en[0]),
        .reg_wr_addr_o (wr_addr[0]),
        .reg_wr_data_o (wr_data[0]),
        .reg_wr_strb_o (wr_strb[0])
    );

    axil_write_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ERR_RESP_EN(1'b1)) u_dut1 (
        .clk_i         (clk),
        .rst_i         (rst[1]),
        .s_axi_awaddr  (awaddr[1]),
        .s_axi_awvalid (awvalid[1]),
        .s_axi_awready (awready[1]),
        .s_axi_wdata   (wdata[1]),
        .s_axi_wstrb   (wstrb[1]),
        .s_axi_wvalid  (wvalid[1]),
        .s_axi_wready  (wready[1]),
        .s_axi_bresp   (bresp[1]),
        .s_axi_bvalid  (bvalid[1]),
        .s_axi_bready  (bready[1]),
`ifdef AXIL_WR_ERR_CNT_EN
        .err_cnt_o     (err_cnt[1]),
`endif
        .reg_wr_en_o   (wr_en[1]),
        .reg_wr_addr_o (wr_addr[1]),
        .reg_wr_data_o (wr_data[1]),
        .reg_wr_strb_o (wr_strb[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One AW/W pair on instance d with given valid delays and bready delay
    // (counted from the first bvalid cycle), checked every cycle.
    task automatic do_txn(input int d, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                          input int b_dly, input string name);
        bit       err_exp;
        bit       aw_done  = 1'b0;
        bit       w_done   = 1'b0;
        bit       finished = 1'b0;
        int       cmp   = -1;
        int       bfirst = -1;
        int       bhs   = -1;
        logic [3:0] exp_ctl;
        logic [3:0] got_ctl;
        logic [1:0] exp_resp;
        err_exp  = (d == 1) && (((addr & AW'(SW - 1)) != '0) || (strb == '0));
        exp_resp = err_exp ? 2'b10 : 2'b00;
        awaddr[d] = addr;
        wdata[d]  = data;
        wstrb[d]  = strb;
        for (int c = 0; c < 60 && !finished; c++) begin
            @(posedge clk); #1;
            awvalid[d] = !aw_done && (c >= aw_dly);
            wvalid[d]  = !w_done && (c >= w_dly);
            bready[d]  = (bfirst >= 0) && (bhs < 0) && (c - bfirst >= b_dly);
            @(negedge clk);
            if (bhs >= 0) begin
                exp_ctl = 4'b1100;
            end else begin
                exp_ctl[3] = !aw_done;
                exp_ctl[2] = !w_done;
                exp_ctl[1] = (cmp >= 0) && (c >= cmp + (err_exp ? 1 : 2));
                exp_ctl[0] = (cmp >= 0) && !err_exp && (c == cmp + 1);
            end
            got_ctl = {awready[d], wready[d], bvalid[d], wr_en[d]};
            n_checks++;
            if (got_ctl !== exp_ctl) begin
                n_fail++;
                $display("FAIL %s dut%0d cycle %0d {awready,wready,bvalid,wr_en}: got %b expected %b",
                         name, d, c, got_ctl, exp_ctl);
            end
            if (exp_ctl[1]) begin
                n_checks++;
                if (bresp[d] !== exp_resp) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cycle %0d bresp: got %b expected %b",
                             name, d, c, bresp[d], exp_resp);
                end
            end
            n_checks++;
            if ({wr_addr[d], wr_data[d], wr_strb[d]} !== {m_addr[d], m_data[d], m_strb[d]}) begin
                n_fail++;
                $display("FAIL %s dut%0d cycle %0d captured beat: got %h/%h/%h expected %h/%h/%h",
                         name, d, c, wr_addr[d], wr_data[d], wr_strb[d], m_addr[d], m_data[d], m_strb[d]);
            end
            if (bhs >= 0) begin
                finished = 1'b1;
            end else begin
                if (exp_ctl[1] && bfirst < 0) bfirst = c;
                if (awvalid[d] && exp_ctl[3]) begin
                    aw_done   = 1'b1;
                    m_addr[d] = addr;
                end
                if (wvalid[d] && exp_ctl[2]) begin
                    w_done    = 1'b1;
                    m_data[d] = data;
                    m_strb[d] = strb;
                end
                if (aw_done && w_done && cmp < 0) cmp = c;
                if (exp_ctl[1] && bready[d]) begin
                    bhs = c;
                    if (err_exp && m_err_cnt[d] < 65535) m_err_cnt[d]++;
                end
            end
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        bready[d]  = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s dut%0d timeout: transaction did not complete (got incomplete, expected done)",
                     name, d);
        end
`ifdef AXIL_WR_ERR_CNT_EN
        n_checks++;
        if (err_cnt[d] !== 16'(m_err_cnt[d])) begin
            n_fail++;
            $display("FAIL %s dut%0d err_cnt: got %0d expected %0d", name, d, err_cnt[d], m_err_cnt[d]);
        end
`endif
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDUT; d++) begin
            rst[d] = 1'b1; awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0;
            awaddr[d] = '1; wdata[d] = '1; wstrb[d] = '1;
            m_addr[d] = '0; m_data[d] = '0; m_strb[d] = '0; m_err_cnt[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            n_checks++;
            if ({awready[d], wready[d], bvalid[d], wr_en[d]} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reset dut%0d ctl: got %b expected 1100", d,
                         {awready[d], wready[d], bvalid[d], wr_en[d]});
            end
            n_checks++;
            if (bresp[d] !== 2'b00) begin
                n_fail++;
                $display("FAIL reset dut%0d bresp: got %b expected 00", d, bresp[d]);
            end
            n_checks++;
            if ({wr_addr[d], wr_data[d], wr_strb[d]} !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d captured beat: got %h/%h/%h expected 0", d,
                         wr_addr[d], wr_data[d], wr_strb[d]);
            end
`ifdef AXIL_WR_ERR_CNT_EN
            n_checks++;
            if (err_cnt[d] !== 16'd0) begin
                n_fail++;
                $display("FAIL reset dut%0d err_cnt: got %0d expected 0", d, err_cnt[d]);
            end
`endif
        end
    endtask

    task automatic test_same_cycle();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, "same_cycle");
    endtask

    task automatic test_aw_first();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h24, 32'h01234567, 4'h3, 0, 3, 0, "aw_first");
    endtask

    task automatic test_w_first();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h38, 32'hCAFEF00D, 4'hC, 2, 0, 1, "w_first");
    endtask

    task automatic test_misaligned();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h12, 32'h55AA55AA, 4'hF, 0, 0, 0, "misaligned");
    endtask

    task automatic test_zero_strb();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h20, 32'h12345678, 4'h0, 1, 0, 0, "zero_strb");
    endtask

    task automatic test_bready_stall();
        for (int d = 0; d < NDUT; d++)
            do_txn(d, 32'h44, 32'h0BADC0DE, 4'h5, 0, 0, 5, "bready_stall");
    endtask

    task automatic test_reset_mid();
        for (int d = 0; d < NDUT; d++) begin
            @(posedge clk); #1;
            awaddr[d] = 32'h40; awvalid[d] = 1'b1;
            @(posedge clk); #1;
            awvalid[d] = 1'b0;
            m_addr[d]  = 32'h40;
            @(negedge clk);
            n_checks++;
            if ({awready[d], wready[d], bvalid[d], wr_en[d], wr_addr[d]} !== {4'b0100, 32'h40}) begin
                n_fail++;
                $display("FAIL reset_mid dut%0d wait_w: got %b/%h expected 0100/00000040", d,
                         {awready[d], wready[d], bvalid[d], wr_en[d]}, wr_addr[d]);
            end
            @(posedge clk); #1;
            rst[d] = 1'b1;
            @(posedge clk); #1;
            rst[d] = 1'b0;
            m_addr[d] = '0; m_data[d] = '0; m_strb[d] = '0; m_err_cnt[d] = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                n_checks++;
                if ({awready[d], wready[d], bvalid[d], wr_en[d]} !== 4'b1100 ||
                    {wr_addr[d], wr_data[d], wr_strb[d]} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid dut%0d after reset cycle %0d: got %b/%h expected 1100/0", d, k,
                             {awready[d], wready[d], bvalid[d], wr_en[d]}, wr_addr[d]);
                end
            end
            do_txn(d, 32'h48, 32'hA5A5A5A5, 4'hF, 0, 1, 0, "reset_mid_followup");
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        logic [SW-1:0] strb;
        for (int i = 0; i < 40; i++) begin
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            strb = SW'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) strb = '0;
            do_txn(i % 2, addr, $urandom, strb, $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_txn(1, 32'h100 + 32'(i * 4) + ((i == 3) ? 32'h1 : 32'h0), 32'(i) * 32'h11111111,
                   4'hF, 0, 0, 0, "back_to_back");
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_aw_first();
        test_w_first();
        test_misaligned();
        test_zero_strb();
        test_bready_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
